sha1_msg_sched: RTL
===================

# sha1_msg_sched

SHA-1 message-schedule generator: the producer side of the `w`/`round` interface consumed by `sha1_round`. It accepts one 512-bit padded message block and streams the 80 schedule words W0..W79, one per handshake, each tagged with a 1-based round number (1..80). It sits between the block padder/buffer and the round datapath/controller.

## Interface
- `N`, default 32: word width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a message block is presented on `in_block`.
- `in_ready`  out  1  the block can be accepted.
- `in_block`  in  512  padded block; word 0 = `in_block[511:480]`, word 15 = `in_block[31:0]` (big-endian word order).
- `flush`  in  1  synchronous abort; returns the block to IDLE.
- `out_valid`  out  1  `out_w` and `out_round` are valid.
- `out_ready`  in  1  the consumer accepts the current word.
- `out_w`  out  32  schedule word W(t), where t = `out_round`-1; this is the `w` input of `sha1_round`.
- `out_round`  out  8  round number, 1..80; this is the `round` input of `sha1_round`.
- `out_last`  out  1  high together with `out_valid` when `out_round`=80.

## Operation
- FSM states are IDLE and RUN. Reset state is IDLE.
- IDLE: `in_ready`=1 and `out_valid`=0. When `in_valid`&`in_ready` is seen, the block does the following:
  - loads the 16-word window buffer;
  - sets `out_w` = word 0 and `out_round` = 1;
  - moves to RUN.
- RUN: `in_ready`=0 (see Configuration) and `out_valid`=1. Each beat with `out_valid`&`out_ready` advances to the next round:
  - t<16: W(t) = word t.
  - t≥16: W(t) = rotl1(W(t-3) ^ W(t-8) ^ W(t-14) ^ W(t-16)).
  - The window is a 16-entry circular buffer with a 4-bit index that wraps 15→0. The new word overwrites slot (t mod 16), the slot that held W(t-16).
- Terminal beat: when `out_round`=80 is accepted, the FSM returns to IDLE, and `out_valid`, `out_last` and `out_round` clear on the next cycle.
- Stall: while `out_valid`=1 and `out_ready`=0, `out_w`, `out_round` and `out_last` hold stable and the window does not change.
- `flush`: in any state, the next cycle is IDLE with `out_valid`=0 and `out_round`=0. `flush` has priority over both handshakes. A block presented in the same cycle as `flush` is not accepted.
- Reset mid-block: the partial schedule is discarded and no stale beat is emitted after reset release.
- Arithmetic: XOR plus a 1-bit left rotate only; no additions. `out_round` is an 8-bit counter that never exceeds 80.

## Timing
- All outputs are registered, except `in_ready`, which decodes from the state.
- Reset values: `out_valid`=0, `out_w`=0, `out_round`=0, `out_last`=0, `in_ready`=1.
- Latency: round 1 is presented in the cycle after the input handshake.
- With `out_ready` held at 1, a block produces 80 consecutive beats over cycles +1..+80 after acceptance.
- Throughput without the macro: one block per 81 cycles, because one IDLE bubble follows each block.
- `out_valid` never drops without a completed handshake, except on `flush` or `rst`.

## Configuration
- `SHA1_SCHED_B2B_EN` defined:
  - In RUN, `in_ready` = `out_last` & `out_ready`.
  - A block accepted on the round-80 beat loads directly, and round 1 of the new block is presented in the next cycle. Steady state is 80 cycles per block with no bubble.
- `SHA1_SCHED_B2B_EN` undefined:
  - `in_ready` = 1 only in IDLE.
  - One bubble cycle follows each block.

## Test plan
- Block for "abc": word0=0x61626380, words 1..14=0, word15=0x00000018; `out_ready`=1.
  - Required: W0=0x61626380, W15=0x00000018, W16=0xC2C4C700, W17=0x00000000, W18=0x00000030.
  - Required: `out_round` runs 1..80, with `out_last` only at 80.
  - Required: all 80 words match a software reference model.
- Random `out_ready` backpressure on a random block.
  - Required: the word sequence is identical to the no-stall run.
  - Required: outputs stay stable on every stalled cycle.
- Assert `flush` at round 40, then present a new block one cycle later.
  - Required: `out_valid`=0 the cycle after `flush`.
  - Required: the new block restarts at round 1 with its own W0.
- Assert `rst` asynchronously at round 20.
  - Required: outputs go immediately to their reset values and `in_ready`=1.
  - Required: after release, the next block schedules correctly from round 1.
- Two blocks queued with `in_valid` held high.
  - Required without the macro: a gap of exactly one cycle with `out_valid`=0 between round 80 and round 1.
  - Required with `SHA1_SCHED_B2B_EN`: zero gap between the blocks.

Source files
------------

// File: rtl/sha1_msg_sched.sv
// SHA-1 message-schedule generator.
//
// Accepts one 512-bit padded block and streams the 80 schedule words W0..W79,
// one per out_valid/out_ready handshake, each tagged with a 1-based round number.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   block handshake; in_block word 0 = in_block[511:480]
//   flush               synchronous abort back to idle (beats both handshakes)
//   out_valid/out_ready schedule-word handshake
//   out_w               W(t), t = out_round - 1
//   out_round           round number 1..80, 0 when idle
//   out_last            marks round 80
//
// Optional feature: define SHA1_SCHED_B2B_EN to accept the next block on the
// round-80 beat, removing the idle bubble between blocks.
module sha1_msg_sched #(
    parameter int unsigned N = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [16*N-1:0] in_block,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_w,
    output logic [7:0]      out_round,
    output logic            out_last
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   win_q [16];
    logic [N-1:0]   win_d [16];
    logic [3:0]     idx_q, idx_d;
    logic [N-1:0]   w_q, w_d;
    logic [7:0]     round_q, round_d;
    logic           last_q, last_d;

    logic           in_fire;
    logic           out_fire;
    logic           load;
    logic [3:0]     idx_nx, idx_m2, idx_m7, idx_p3;
    logic [N-1:0]   mix;
    logic [N-1:0]   w_next;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StRun: begin
`ifdef SHA1_SCHED_B2B_EN
                in_ready = last_q & out_ready;
`else
                in_ready = 1'b0;
`endif
            end
        endcase
    end

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = (state_q == StRun) & out_ready;

    // idx_q holds slot t mod 16 of the word currently presented; the next word
    // W(t+1) lands in slot idx_q+1, which holds W(t-15) until overwritten.
    always_comb begin
        idx_nx = idx_q + 4'd1;
        idx_m2 = idx_q - 4'd2;   // W(t+1-3)
        idx_m7 = idx_q - 4'd7;   // W(t+1-8)
        idx_p3 = idx_q + 4'd3;   // W(t+1-14)
        mix    = win_q[idx_m2] ^ win_q[idx_m7] ^ win_q[idx_p3] ^ win_q[idx_nx];
        // out_round = t+1, so out_round < 16 means W(t+1) is still a message word
        w_next = (round_q < 8'd16) ? win_q[idx_nx] : {mix[N-2:0], mix[N-1]};
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        w_d     = w_q;
        round_d = round_q;
        last_d  = last_q;
        load    = 1'b0;

        if (flush) begin
            state_d = StIdle;
            round_d = 8'd0;
            last_d  = 1'b0;
        end else if (state_q == StIdle) begin
            load = in_fire;
        end else if (out_fire) begin
            if (last_q) begin
                if (in_fire) begin
                    load = 1'b1;
                end else begin
                    state_d = StIdle;
                    round_d = 8'd0;
                    last_d  = 1'b0;
                end
            end else begin
                win_d[idx_nx] = w_next;
                idx_d         = idx_nx;
                w_d           = w_next;
                round_d       = round_q + 8'd1;
                last_d        = (round_q == 8'd79);
            end
        end

        if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = in_block[(15-i)*N +: N];
            end
            w_d     = in_block[16*N-1 -: N];
            idx_d   = 4'd0;
            round_d = 8'd1;
            last_d  = 1'b0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
            idx_q   <= 4'd0;
            w_q     <= '0;
            round_q <= 8'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            w_q     <= w_d;
            round_q <= round_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == StRun);
    assign out_w     = w_q;
    assign out_round = round_q;
    assign out_last  = last_q;

endmodule
